// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-stage stall/bubble strobes, run state, status and counters.
// Optional single-step support is built when PIPE_CTRL_STEP_EN is defined.
module pipe_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [3:0]       D_icode_i,
   input  logic [3:0]       d_srcA_i,
   input  logic [3:0]       d_srcB_i,
   input  logic [3:0]       E_icode_i,
   input  logic [3:0]       E_dstM_i,
   input  logic             e_Cnd_i,
   input  logic [3:0]       M_icode_i,
   input  logic [2:0]       m_stat_i,
   input  logic [2:0]       W_stat_i,
   input  logic             dmem_ready_i,
`ifdef PIPE_CTRL_STEP_EN
   input  logic             step_i,
   output logic             step_busy_o,
`endif
   output logic             F_stall_o,
   output logic             D_stall_o,
   output logic             D_bubble_o,
   output logic             E_stall_o,
   output logic             E_bubble_o,
   output logic             M_stall_o,
   output logic             M_bubble_o,
   output logic             W_stall_o,
   output logic             W_bubble_o,
   output logic             set_cc_o,
   output logic             halted_o,
   output logic [2:0]       cpu_stat_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] R_NONE   = 4'hF;
   localparam logic [2:0] S_AOK    = 3'd1;

   typedef enum logic [1:0] {
      ST_FLUSH = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic load_use, ret_pend, mispred, mem_acc, mem_wait, exc_m, exc_w;
   logic run_active;

   assign load_use = (E_icode_i inside {I_MRMOVQ, I_POPQ}) && (E_dstM_i != R_NONE) &&
                     ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
   assign ret_pend = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
   assign mispred  = (E_icode_i == I_JXX) && !e_Cnd_i;
   assign mem_acc  = M_icode_i inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
   assign mem_wait = mem_acc && !dmem_ready_i;
   assign exc_m    = m_stat_i inside {3'd2, 3'd3, 3'd4};
   assign exc_w    = W_stat_i inside {3'd2, 3'd3, 3'd4};

`ifdef PIPE_CTRL_STEP_EN
   // A step edge releases one cycle; a release that hits mem_wait is held until memory is ready.
   logic step_q, hold_q;

   assign run_active  = (step_i && !step_q) || hold_q;
   assign step_busy_o = (state == ST_RUN) && run_active;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         step_q <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         step_q <= step_i;
         hold_q <= (state == ST_RUN) && run_active && mem_wait;
      end
   end
`else
   assign run_active = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= ST_FLUSH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      F_stall_o  = 1'b0;
      D_stall_o  = 1'b0;
      D_bubble_o = 1'b0;
      E_stall_o  = 1'b0;
      E_bubble_o = 1'b0;
      M_stall_o  = 1'b0;
      M_bubble_o = 1'b0;
      W_stall_o  = 1'b0;
      W_bubble_o = 1'b0;
      set_cc_o   = 1'b0;
      unique case (state)
         ST_FLUSH: begin
            state_nxt  = ST_RUN;
            D_bubble_o = 1'b1;
            E_bubble_o = 1'b1;
            M_bubble_o = 1'b1;
            W_bubble_o = 1'b1;
         end
         ST_RUN: begin
            if (!run_active) begin
               F_stall_o = 1'b1;
               D_stall_o = 1'b1;
               E_stall_o = 1'b1;
               M_stall_o = 1'b1;
               W_stall_o = 1'b1;
            end else begin
               if (exc_w) state_nxt = ST_HALT;
               if (mem_wait) begin
                  F_stall_o  = 1'b1;
                  D_stall_o  = 1'b1;
                  E_stall_o  = 1'b1;
                  M_stall_o  = 1'b1;
                  W_bubble_o = 1'b1;
               end else begin
                  // Stall beats bubble on D: a load-use hold must not discard the waiting instruction.
                  F_stall_o  = load_use || ret_pend;
                  D_stall_o  = load_use;
                  D_bubble_o = mispred || (ret_pend && !load_use);
                  E_bubble_o = mispred || load_use;
                  M_bubble_o = exc_m || exc_w;
                  W_stall_o  = exc_w;
                  set_cc_o   = (E_icode_i == I_OPQ) && !exc_m && !exc_w;
               end
            end
         end
         ST_HALT: begin
            F_stall_o = 1'b1;
            D_stall_o = 1'b1;
            E_stall_o = 1'b1;
            M_stall_o = 1'b1;
            W_stall_o = 1'b1;
         end
         default: state_nxt = ST_FLUSH;
      endcase
   end

   assign halted_o = (state == ST_HALT);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cpu_stat_o   <= S_AOK;
         cycle_cnt_o  <= '0;
         retire_cnt_o <= '0;
      end else if ((state == ST_RUN) && run_active) begin
         cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
         if ((W_stat_i == S_AOK) && !W_stall_o)
            retire_cnt_o <= retire_cnt_o + CNT_W'(1);
         if (exc_w)
            cpu_stat_o <= W_stat_i;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard steps followed by random traffic,
// checked against a rule-level model; a second 4-bit-counter instance exercises wrap.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic       e_Cnd, dmem_ready;
   logic [2:0] m_stat, W_stat;

   logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, set_cc;
   logic halted;
   logic [2:0] cpu_stat;
   logic [31:0] cycle_cnt, retire_cnt;

   logic s_F_stall, s_D_stall, s_D_bubble, s_E_stall, s_E_bubble, s_M_stall, s_M_bubble;
   logic s_W_stall, s_W_bubble, s_set_cc, s_halted;
   logic [2:0] s_cpu_stat;
   logic [3:0] s_cycle_cnt, s_retire_cnt;

   pipe_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
      .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
      .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat), .dmem_ready_i(dmem_ready),
      .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
      .E_stall_o(E_stall), .E_bubble_o(E_bubble), .M_stall_o(M_stall), .M_bubble_o(M_bubble),
      .W_stall_o(W_stall), .W_bubble_o(W_bubble), .set_cc_o(set_cc),
      .halted_o(halted), .cpu_stat_o(cpu_stat),
      .cycle_cnt_o(cycle_cnt), .retire_cnt_o(retire_cnt)
   );

   pipe_ctrl #(.CNT_W(4)) dut_small (
      .clk_i(clk), .rst_n_i(rst_n),
      .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
      .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
      .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat), .dmem_ready_i(dmem_ready),
      .F_stall_o(s_F_stall), .D_stall_o(s_D_stall), .D_bubble_o(s_D_bubble),
      .E_stall_o(s_E_stall), .E_bubble_o(s_E_bubble), .M_stall_o(s_M_stall), .M_bubble_o(s_M_bubble),
      .W_stall_o(s_W_stall), .W_bubble_o(s_W_bubble), .set_cc_o(s_set_cc),
      .halted_o(s_halted), .cpu_stat_o(s_cpu_stat),
      .cycle_cnt_o(s_cycle_cnt), .retire_cnt_o(s_retire_cnt)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: run phase as flags, architectural counters as plain integers.
   bit          mdl_flush, mdl_halt;
   logic [2:0]  mdl_stat;
   int unsigned mdl_cycles, mdl_retired;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic bit is_exc(input logic [2:0] s);
      return (s >= 3'd2) && (s <= 3'd4);
   endfunction

   function automatic bit touches_mem(input logic [3:0] ic);
      return (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
   endfunction

   // Bit order: F_stall D_stall D_bubble E_stall E_bubble M_stall M_bubble W_stall W_bubble set_cc
   function automatic logic [9:0] expect_strobes();
      logic [9:0] r;
      bit lu, rp, mp, exm, exw;
      if (mdl_halt)  return 10'b1101010100;
      if (mdl_flush) return 10'b0010101010;
      if (touches_mem(M_icode) && !dmem_ready) return 10'b1101010010;
      lu  = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      rp  = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
      mp  = (E_icode == 4'h7) && !e_Cnd;
      exm = is_exc(m_stat);
      exw = is_exc(W_stat);
      r    = '0;
      r[9] = lu || rp;
      r[8] = lu;
      r[7] = mp || (rp && !lu);
      r[5] = mp || lu;
      r[3] = exm || exw;
      r[2] = exw;
      r[0] = (E_icode == 4'h6) && !exm && !exw;
      return r;
   endfunction

   task automatic model_edge();
      if (mdl_halt) return;
      if (mdl_flush) begin
         mdl_flush = 1'b0;
         return;
      end
      mdl_cycles++;
      if ((W_stat == 3'd1) && !is_exc(W_stat)) mdl_retired++;
      if (is_exc(W_stat)) begin
         mdl_halt = 1'b1;
         mdl_stat = W_stat;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] a_D, input logic [3:0] a_sA, input logic [3:0] a_sB,
                                input logic [3:0] a_E, input logic [3:0] a_dM, input logic a_cnd,
                                input logic [3:0] a_M, input logic [2:0] a_ms, input logic [2:0] a_ws,
                                input logic a_rdy);
      D_icode = a_D;  d_srcA = a_sA; d_srcB = a_sB;
      E_icode = a_E;  E_dstM = a_dM; e_Cnd = a_cnd;
      M_icode = a_M;  m_stat = a_ms; W_stat = a_ws; dmem_ready = a_rdy;
   endtask

   // Called just after a falling edge with inputs driven; returns at the next falling edge.
   task automatic checkOutput(input string tag);
      #1;
      check({tag, "/strobes"}, {F_stall, D_stall, D_bubble, E_stall, E_bubble,
                                M_stall, M_bubble, W_stall, W_bubble, set_cc}, expect_strobes());
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "/halted"}, halted, mdl_halt);
      check({tag, "/stat"}, cpu_stat, mdl_stat);
      check({tag, "/cycles"}, cycle_cnt, mdl_cycles);
      check({tag, "/retired"}, retire_cnt, mdl_retired);
      check({tag, "/cycles4"}, s_cycle_cnt, mdl_cycles % 16);
      check({tag, "/retired4"}, s_retire_cnt, mdl_retired % 16);
      @(negedge clk);
   endtask

   // Asserts reset between edges, checks the immediate clear, releases on a falling edge.
   task automatic doReset();
      #3 rst_n = 1'b0;
      mdl_flush = 1'b1; mdl_halt = 1'b0; mdl_stat = 3'd1;
      mdl_cycles = 0;   mdl_retired = 0;
      #1;
      check("reset/strobes", {F_stall, D_stall, D_bubble, E_stall, E_bubble,
                              M_stall, M_bubble, W_stall, W_bubble, set_cc}, 10'b0010101010);
      check("reset/halted", halted, 1'b0);
      check("reset/stat", cpu_stat, 3'd1);
      check("reset/cycles", cycle_cnt, 32'd0);
      check("reset/retired", retire_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic nop_cycle(input string tag);
      applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput(tag);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int halt_cycles;
      logic [3:0] rD, rE, rM;
      logic [2:0] rms, rws;
      logic rrdy;

      rst_n = 1'b1;
      applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      @(negedge clk);
      doReset();

      nop_cycle("flush");
      for (int i = 0; i < 4; i++) nop_cycle("idle");

      applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("load_use_a");
      applyStimulus(4'h1, 4'hF, 4'h3, 4'hB, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("load_use_pop");
      applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("no_load_use");

      applyStimulus(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("mispred");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
         checkOutput("ret");
      end
      applyStimulus(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("lu_ret");

      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h5, 3'd1, 3'd0, 1'b0);
         checkOutput("mem_wait");
      end
      applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h5, 3'd1, 3'd1, 1'b1);
      checkOutput("mem_ready");

      applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 3'd1, 1'b1);
      checkOutput("opq");
      applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd3, 3'd1, 1'b1);
      checkOutput("exc_m");
      applyStimulus(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 3'd1, 3'd3, 1'b1);
      checkOutput("exc_w");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'($urandom_range(0, 11)), 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h5, 3'd1, 3'd1, 1'b1);
         checkOutput("halt");
      end
      doReset();

      nop_cycle("flush2");
      for (int i = 0; i < 16; i++) nop_cycle("count16");
      check("wrap4", s_cycle_cnt, 4'd0);

      halt_cycles = 0;
      for (int i = 0; i < 400; i++) begin
         if (mdl_halt && (halt_cycles >= 3)) begin
            doReset();
            halt_cycles = 0;
         end
         rD   = 4'($urandom_range(0, 11));
         rE   = 4'($urandom_range(0, 11));
         rM   = 4'($urandom_range(0, 11));
         rms  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
         rws  = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'($urandom_range(0, 1));
         rrdy = ($urandom_range(0, 3) != 0);
         if (is_exc(rws)) rrdy = 1'b1;
         if (touches_mem(rM) && !rrdy) rws = 3'd0;
         applyStimulus(rD, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rE,
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rM, rms, rws, rrdy);
         checkOutput("rand");
         if (mdl_halt) halt_cycles++;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
